// File: rtl/sha3_pkg.sv
// Shared widths, padding constants and FSM state type for the SHA-3 absorb sequencer.
package sha3_pkg;
  localparam int LANE_W       = 64;
  localparam int GROUP_LANES  = 5;
  localparam logic [LANE_W-1:0] PAD_FIRST = 64'h06;
  localparam int PAD_LAST_BIT = 63;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    ISSUE,
    PERM,
    PERM_LAST
  } absorb_state_t;
endpackage

// File: rtl/sha3_absorb_sequencer_if.sv
// Host lane stream, slicer group bus and permutation handshake of the absorb sequencer.
interface sha3_absorb_sequencer_if ();
  logic                                                 in_valid;
  logic [sha3_pkg::LANE_W-1:0]                          in_data;
  logic                                                 in_last;
  logic                                                 in_ready;
  logic [sha3_pkg::GROUP_LANES-1:0][sha3_pkg::LANE_W-1:0] grp_elt;
  logic [sha3_pkg::GROUP_LANES-1:0]                     grp_mask;
  logic [2:0]                                           grp_idx;
  logic                                                 grp_valid;
  logic                                                 grp_ready;
  logic                                                 perm_start;
  logic                                                 perm_done;
  logic                                                 msg_done;

  // master = host/datapath side, slave = the sequencer
  modport master (
    output in_valid, in_data, in_last, grp_ready, perm_done,
    input  in_ready, grp_elt, grp_mask, grp_idx, grp_valid, perm_start, msg_done
  );
  modport slave (
    input  in_valid, in_data, in_last, grp_ready, perm_done,
    output in_ready, grp_elt, grp_mask, grp_idx, grp_valid, perm_start, msg_done
  );
endinterface

// File: rtl/sha3_pad_lane.sv
// Combinational SHA-3 pad lane: 0x06 on the first pad lane, bit 63 on the block's last lane.
module sha3_pad_lane
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = 17,
  parameter int CNT_W      = $clog2(RATE_LANES + 1)
) (
  input  logic [CNT_W-1:0]  lane_idx,
  input  logic              first_pad,
  output logic [LANE_W-1:0] pad_lane
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_LANES - 1);

  always_comb begin
    pad_lane = first_pad ? PAD_FIRST : '0;
    if (lane_idx == LAST_IDX) begin
      pad_lane[PAD_LAST_BIT] = 1'b1;
    end
  end
endmodule

// File: rtl/sha3_absorb_sequencer.sv
// Groups message lanes five at a time for the slicer, inserts SHA-3 padding and
// starts one Keccak permutation per rate block.
module sha3_absorb_sequencer
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = 17
) (
  input logic                    clk,
  input logic                    rst,
  sha3_absorb_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(RATE_LANES + 1);
  localparam logic [CNT_W-1:0] RATE_CNT = CNT_W'(RATE_LANES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_LANES - 1);

  absorb_state_t                        state_reg;
  logic [CNT_W-1:0]                     lane_cnt_reg;
  logic [2:0]                           slot_reg;
  logic [2:0]                           grp_idx_reg;
  logic                                 pad_active_reg;
  logic                                 first_pad_reg;
  logic                                 carries_last_reg;
  logic                                 in_ready_reg;
  logic                                 grp_valid_reg;
  logic                                 perm_start_reg;
  logic                                 msg_done_reg;
  logic [GROUP_LANES-1:0][LANE_W-1:0]   elt_reg;
  logic [GROUP_LANES-1:0]               mask_reg;

  logic                                 accept;
  logic                                 take;
  logic                                 closes;
  logic [LANE_W-1:0]                    pad_lane;
  logic [LANE_W-1:0]                    wr_data;
  logic [GROUP_LANES-1:0]               slot_wr;

  sha3_pad_lane #(
    .RATE_LANES (RATE_LANES),
    .CNT_W      (CNT_W)
  ) u_pad (
    .lane_idx  (lane_cnt_reg),
    .first_pad (first_pad_reg),
    .pad_lane  (pad_lane)
  );

  assign accept  = (state_reg == FILL) && in_ready_reg && bus.in_valid;
  assign take    = grp_valid_reg && bus.grp_ready;
  assign closes  = (slot_reg == 3'd4) || (lane_cnt_reg == LAST_IDX);
  assign wr_data = accept ? bus.in_data : pad_lane;

  genvar gi;
  generate
    for (gi = 0; gi < GROUP_LANES; gi++) begin : g_slot_wr
      assign slot_wr[gi] = (accept || (state_reg == PAD)) && (slot_reg == 3'(gi));
    end
  endgenerate

  // Consumed groups are zeroed so partially filled groups present zero in unused slots.
  always_ff @(posedge clk) begin
    if (rst || take) begin
      elt_reg  <= '0;
      mask_reg <= '0;
    end else begin
      for (int i = 0; i < GROUP_LANES; i++) begin
        if (slot_wr[i]) begin
          elt_reg[i]  <= wr_data;
          mask_reg[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= FILL;
      lane_cnt_reg     <= '0;
      slot_reg         <= '0;
      grp_idx_reg      <= '0;
      pad_active_reg   <= 1'b0;
      first_pad_reg    <= 1'b0;
      carries_last_reg <= 1'b0;
      in_ready_reg     <= 1'b0;
      grp_valid_reg    <= 1'b0;
      perm_start_reg   <= 1'b0;
      msg_done_reg     <= 1'b0;
    end else begin
      perm_start_reg <= 1'b0;
      msg_done_reg   <= 1'b0;
      case (state_reg)
        FILL: begin
          if (accept) begin
            lane_cnt_reg <= lane_cnt_reg + CNT_W'(1);
            slot_reg     <= slot_reg + 3'd1;
            if (bus.in_last) begin
              pad_active_reg <= 1'b1;
              first_pad_reg  <= 1'b1;
            end
            if (closes) begin
              state_reg     <= ISSUE;
              in_ready_reg  <= 1'b0;
              grp_valid_reg <= 1'b1;
            end else if (bus.in_last) begin
              state_reg    <= PAD;
              in_ready_reg <= 1'b0;
            end
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        PAD: begin
          lane_cnt_reg  <= lane_cnt_reg + CNT_W'(1);
          slot_reg      <= slot_reg + 3'd1;
          first_pad_reg <= 1'b0;
          if (lane_cnt_reg == LAST_IDX) begin
            carries_last_reg <= 1'b1;
          end
          if (closes) begin
            state_reg     <= ISSUE;
            grp_valid_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (take) begin
            grp_valid_reg <= 1'b0;
            grp_idx_reg   <= grp_idx_reg + 3'd1;
            slot_reg      <= '0;
            if (lane_cnt_reg == RATE_CNT) begin
              state_reg      <= carries_last_reg ? PERM_LAST : PERM;
              perm_start_reg <= 1'b1;
            end else if (pad_active_reg) begin
              state_reg <= PAD;
            end else begin
              state_reg    <= FILL;
              in_ready_reg <= 1'b1;
            end
          end
        end
        PERM, PERM_LAST: begin
          if (bus.perm_done) begin
            lane_cnt_reg     <= '0;
            grp_idx_reg      <= '0;
            carries_last_reg <= 1'b0;
            if (state_reg == PERM_LAST) begin
              msg_done_reg   <= 1'b1;
              pad_active_reg <= 1'b0;
              state_reg      <= FILL;
              in_ready_reg   <= 1'b1;
            end else if (pad_active_reg) begin
              // in_last landed on the block's final lane: a pure padding block follows
              state_reg <= PAD;
            end else begin
              state_reg    <= FILL;
              in_ready_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.grp_valid  = grp_valid_reg;
  assign bus.grp_elt    = elt_reg;
  assign bus.grp_mask   = mask_reg;
  assign bus.grp_idx    = grp_idx_reg;
  assign bus.perm_start = perm_start_reg;
  assign bus.msg_done   = msg_done_reg;
endmodule

// File: tb/tb_sha3_absorb_sequencer.sv
// Directed bench for the absorb sequencer: RATE_LANES=17 and RATE_LANES=9 instances share stimulus.
module tb_sha3_absorb_sequencer;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] P6 = 64'h0000_0000_0000_0006;
  localparam logic [63:0] PL = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PB = 64'h8000_0000_0000_0006;
  localparam logic [63:0] D1 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] D2 = 64'h2222_0000_0000_0000;
  localparam logic [63:0] D3 = 64'h3333_0000_0000_0000;
  localparam logic [63:0] D5 = 64'h5555_0000_0000_0000;
  localparam logic [63:0] D6 = 64'h6666_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, grp_ready = 1'b0, perm_done = 1'b0;
  logic [63:0] in_data = '0;

  logic            in_ready, grp_valid, perm_start, msg_done;
  logic [4:0]      grp_mask;
  logic [2:0]      grp_idx;
  logic [4:0][63:0] grp_elt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_msgs   = 0;

  always #5 clk = ~clk;

  sha3_absorb_sequencer_if b17 ();
  sha3_absorb_sequencer_if b9 ();

  assign b17.in_valid  = in_valid & ~sel;
  assign b17.in_data   = in_data;
  assign b17.in_last   = in_last;
  assign b17.grp_ready = grp_ready & ~sel;
  assign b17.perm_done = perm_done & ~sel;
  assign b9.in_valid   = in_valid & sel;
  assign b9.in_data    = in_data;
  assign b9.in_last    = in_last;
  assign b9.grp_ready  = grp_ready & sel;
  assign b9.perm_done  = perm_done & sel;

  assign in_ready   = sel ? b9.in_ready   : b17.in_ready;
  assign grp_valid  = sel ? b9.grp_valid  : b17.grp_valid;
  assign perm_start = sel ? b9.perm_start : b17.perm_start;
  assign msg_done   = sel ? b9.msg_done   : b17.msg_done;
  assign grp_mask   = sel ? b9.grp_mask   : b17.grp_mask;
  assign grp_idx    = sel ? b9.grp_idx    : b17.grp_idx;
  assign grp_elt    = sel ? b9.grp_elt    : b17.grp_elt;

  sha3_absorb_sequencer #(.RATE_LANES(17)) dut17 (.clk(clk), .rst(rst), .bus(b17));
  sha3_absorb_sequencer #(.RATE_LANES(9))  dut9  (.clk(clk), .rst(rst), .bus(b9));

  always @(negedge clk) begin
    if (perm_start) n_starts++;
    if (msg_done) n_msgs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0][63:0] grp(input logic [63:0] e0, e1, e2, e3, e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  task automatic send(input logic [63:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    tick();
    $display("lane %h last=%0b accepted", d, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_group(input logic [2:0] idx, input logic [4:0] mask, input logic [4:0][63:0] e);
    int n = 0;
    while (!grp_valid && n < 30) begin
      tick();
      n++;
    end
    chk("grp_valid", grp_valid, 1'b1);
    chk($sformatf("grp_idx_%0d", idx), grp_idx, idx);
    chk($sformatf("grp_mask_%0d", idx), grp_mask, mask);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("grp%0d_elt%0d", idx, i), grp_elt[i], e[i]);
    end
    chk("in_ready_issue", in_ready, 1'b0);
    $display("group idx=%0d mask=%h elt0=%h elt1=%h", grp_idx, grp_mask, grp_elt[0], grp_elt[1]);
    grp_ready = 1'b1;
    tick();
    grp_ready = 1'b0;
    chk("grp_valid_drop", grp_valid, 1'b0);
  endtask

  task automatic expect_perm(input logic last, input logic rdy);
    chk("perm_start", perm_start, 1'b1);
    tick();
    chk("perm_start_pulse", perm_start, 1'b0);
    repeat (3) tick();
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    chk("msg_done", msg_done, last);
    chk("resume_ready", in_ready, rdy);
    $display("perm done last=%0b msg_done=%0b in_ready=%0b", last, msg_done, in_ready);
    if (last) begin
      tick();
      chk("msg_done_pulse", msg_done, 1'b0);
    end
  endtask

  initial begin
    int s0;
    int m0;

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_grp_valid", grp_valid, 1'b0);
    chk("rst_grp_mask", grp_mask, 5'h0);
    chk("rst_grp_idx", grp_idx, 3'h0);
    chk("rst_grp_elt0", grp_elt[0], Z);
    chk("rst_perm_start", perm_start, 1'b0);
    chk("rst_msg_done", msg_done, 1'b0);
    rst = 1'b0;
    chk("ready_low_after_rst", in_ready, 1'b0);
    tick();
    chk("ready_rise", in_ready, 1'b1);

    // 17 lanes, in_last on lane 16: data block then a pure padding block
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) send(D1 + 64'(5 * g + i), 1'b0);
      expect_group(3'(g), 5'h1F, grp(D1 + 64'(5 * g), D1 + 64'(5 * g + 1), D1 + 64'(5 * g + 2),
                                     D1 + 64'(5 * g + 3), D1 + 64'(5 * g + 4)));
    end
    send(D1 + 64'd15, 1'b0);
    send(D1 + 64'd16, 1'b1);
    expect_group(3'd3, 5'h03, grp(D1 + 64'd15, D1 + 64'd16, Z, Z, Z));
    expect_perm(1'b0, 1'b0);
    expect_group(3'd0, 5'h1F, grp(P6, Z, Z, Z, Z));
    expect_group(3'd1, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd2, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd3, 5'h03, grp(Z, PL, Z, Z, Z));
    expect_perm(1'b1, 1'b1);

    // 3 lanes, in_last on lane 2: padding completes the same block
    s0 = n_starts;
    send(D2 + 64'd0, 1'b0);
    send(D2 + 64'd1, 1'b0);
    send(D2 + 64'd2, 1'b1);
    expect_group(3'd0, 5'h1F, grp(D2 + 64'd0, D2 + 64'd1, D2 + 64'd2, P6, Z));
    expect_group(3'd1, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd2, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd3, 5'h03, grp(Z, PL, Z, Z, Z));
    expect_perm(1'b1, 1'b1);
    chk("one_perm_start", 64'(n_starts - s0), 64'd1);

    // 16 lanes, in_last on lane 15, with a 10-cycle grp_ready stall on group 0
    for (int i = 0; i < 5; i++) send(D3 + 64'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = D3 + 64'd5;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", grp_valid, 1'b1);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_elt4", grp_elt[4], D3 + 64'd4);
      chk("stall_mask", grp_mask, 5'h1F);
    end
    in_valid = 1'b0;
    expect_group(3'd0, 5'h1F, grp(D3, D3 + 64'd1, D3 + 64'd2, D3 + 64'd3, D3 + 64'd4));
    for (int g = 1; g < 3; g++) begin
      for (int i = 0; i < 5; i++) send(D3 + 64'(5 * g + i), 1'b0);
      expect_group(3'(g), 5'h1F, grp(D3 + 64'(5 * g), D3 + 64'(5 * g + 1), D3 + 64'(5 * g + 2),
                                     D3 + 64'(5 * g + 3), D3 + 64'(5 * g + 4)));
    end
    send(D3 + 64'd15, 1'b1);
    expect_group(3'd3, 5'h03, grp(D3 + 64'd15, PB, Z, Z, Z));
    expect_perm(1'b1, 1'b1);

    // full block without in_last, reset while in PERM, stale perm_done, then a 1-lane message
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) send(D5 + 64'(5 * g + i), 1'b0);
      expect_group(3'(g), 5'h1F, grp(D5 + 64'(5 * g), D5 + 64'(5 * g + 1), D5 + 64'(5 * g + 2),
                                     D5 + 64'(5 * g + 3), D5 + 64'(5 * g + 4)));
    end
    send(D5 + 64'd15, 1'b0);
    send(D5 + 64'd16, 1'b0);
    expect_group(3'd3, 5'h03, grp(D5 + 64'd15, D5 + 64'd16, Z, Z, Z));
    chk("perm_before_rst", perm_start, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    s0 = n_starts;
    m0 = n_msgs;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_grp_valid", grp_valid, 1'b0);
    chk("midrst_grp_idx", grp_idx, 3'h0);
    chk("midrst_grp_mask", grp_mask, 5'h0);
    rst = 1'b0;
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    tick();
    chk("stale_msg_done", 64'(n_msgs - m0), 64'd0);
    chk("stale_perm_start", 64'(n_starts - s0), 64'd0);
    chk("post_rst_ready", in_ready, 1'b1);
    send(D5 + 64'd100, 1'b1);
    expect_group(3'd0, 5'h1F, grp(D5 + 64'd100, P6, Z, Z, Z));
    expect_group(3'd1, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd2, 5'h1F, grp(Z, Z, Z, Z, Z));
    expect_group(3'd3, 5'h03, grp(Z, PL, Z, Z, Z));
    expect_perm(1'b1, 1'b1);

    // RATE_LANES=9 instance: 9 lanes, in_last on lane 8
    sel = 1'b1;
    chk("r9_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) send(D6 + 64'(i), 1'b0);
    expect_group(3'd0, 5'h1F, grp(D6, D6 + 64'd1, D6 + 64'd2, D6 + 64'd3, D6 + 64'd4));
    for (int i = 5; i < 9; i++) send(D6 + 64'(i), i == 8);
    expect_group(3'd1, 5'h0F, grp(D6 + 64'd5, D6 + 64'd6, D6 + 64'd7, D6 + 64'd8, Z));
    expect_perm(1'b0, 1'b0);
    expect_group(3'd0, 5'h1F, grp(P6, Z, Z, Z, Z));
    expect_group(3'd1, 5'h0F, grp(Z, Z, Z, PL, Z));
    expect_perm(1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
